mem_arbiter: RTL

Two-port arbiter that shares the single-ported, registered-read `Memory` between the CPU (port 0) and a second bus master (port 1), e.g. a program loader or DMA engine. It sits in `SOC` between the requesters and `RAM`. It latches one-cycle read/write strobes from each port, serialises them onto the memory bus with round-robin or fixed priority, and returns read data through per-port registers with busy handshakes.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported, registered-read memory.
// Each port owns one pending slot; the arbiter issues one transfer at a time.
module mem_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic                  p0_rstrb,
    input  logic [3:0]            p0_wmask,
    input  logic [31:0]           p0_wdata,
    output logic [31:0]           p0_rdata,
    output logic                  p0_rbusy,
    output logic                  p0_wbusy,

    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic                  p1_rstrb,
    input  logic [3:0]            p1_wmask,
    input  logic [31:0]           p1_wdata,
    output logic [31:0]           p1_rdata,
    output logic                  p1_rbusy,
    output logic                  p1_wbusy,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rstrb,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic {
        IDLE  = 1'b0,
        RDATA = 1'b1
    } state_t;

    state_t                state;
    logic [1:0]            pend;
    logic [1:0]            kind_w;
    logic [ADDR_WIDTH-1:0] slot_addr  [2];
    logic [31:0]           slot_wdata [2];
    logic [3:0]            slot_wmask [2];
    logic                  last_grant;

    logic                  req0;
    logic                  req1;
    logic                  grant;
    logic                  sel;

    // A write strobe wins over a simultaneous read strobe on the same port.
    assign req0 = p0_rstrb | (p0_wmask != 4'd0);
    assign req1 = p1_rstrb | (p1_wmask != 4'd0);

    // last_grant doubles as the held selection while a read is in RDATA.
    always_comb begin
        grant = 1'b0;
        sel   = last_grant;
        if (state == IDLE && pend != 2'b00) begin
            grant = 1'b1;
            if (pend == 2'b11) begin
                sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
            end else begin
                sel = pend[1];
            end
        end
    end

    assign mem_addr  = slot_addr[sel];
    assign mem_wdata = slot_wdata[sel];
    assign mem_rstrb = grant & ~kind_w[sel];
    assign mem_wmask = (grant & kind_w[sel]) ? slot_wmask[sel] : 4'd0;

    assign p0_rbusy  = pend[0] & ~kind_w[0];
    assign p0_wbusy  = pend[0] &  kind_w[0];
    assign p1_rbusy  = pend[1] & ~kind_w[1];
    assign p1_wbusy  = pend[1] &  kind_w[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pend          <= 2'b00;
            kind_w        <= 2'b00;
            last_grant    <= 1'b1;
            slot_addr[0]  <= '0;
            slot_addr[1]  <= '0;
            slot_wdata[0] <= 32'd0;
            slot_wdata[1] <= 32'd0;
            slot_wmask[0] <= 4'd0;
            slot_wmask[1] <= 4'd0;
            p0_rdata      <= 32'd0;
            p1_rdata      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        last_grant <= sel;
                        if (kind_w[sel]) begin
                            pend[sel] <= 1'b0;
                        end else begin
                            state <= RDATA;
                        end
                    end
                end
                RDATA: begin
                    if (last_grant) begin
                        p1_rdata <= mem_rdata;
                    end else begin
                        p0_rdata <= mem_rdata;
                    end
                    pend[last_grant] <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Strobes arriving while the slot is occupied are dropped.
            if (!pend[0] && req0) begin
                pend[0]       <= 1'b1;
                kind_w[0]     <= (p0_wmask != 4'd0);
                slot_addr[0]  <= p0_addr;
                slot_wdata[0] <= p0_wdata;
                slot_wmask[0] <= p0_wmask;
            end
            if (!pend[1] && req1) begin
                pend[1]       <= 1'b1;
                kind_w[1]     <= (p1_wmask != 4'd0);
                slot_addr[1]  <= p1_addr;
                slot_wdata[1] <= p1_wdata;
                slot_wmask[1] <= p1_wmask;
            end
        end
    end

endmodule
